// File: rtl/moving_average_param.sv
// moving_average_param: windowed running sum over the last 2**LOG2_WIN
// unsigned samples of a frame, with frame delimiting via last_i.
//
// Build option: define MOVING_AVERAGE_NORM_EN to output the window mean
// (sum >> LOG2_WIN, truncating) instead of the raw running sum. Port widths
// and latency are the same in both builds.
//
// The sum is kept incrementally: each accepted sample adds itself and, once
// the window is full, subtracts the entry it overwrites in the circular
// buffer. Because the subtracted entry is always part of the current sum,
// the subtraction cannot underflow. The sum is DATA_W+LOG2_WIN bits wide,
// which is enough to hold WIN full-scale samples, so it never overflows.
//
// Results appear one cycle after the accepted sample. During warm-up the
// partial sum is reported as-is. A sample with last_i=1 produces its result
// normally and then clears sum, fill count and write pointer, so the next
// sample opens a fresh window. The buffer itself is never reset; entries
// left over from an earlier frame are only read once the fill count says the
// window is full, by which point they have all been overwritten.

module moving_average_param #(
    parameter int DATA_W   = 32,
    parameter int LOG2_WIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic                       last_i,
    input  logic [DATA_W-1:0]          in,
    output logic                       valid_o,
    output logic                       last_o,
    output logic [DATA_W+LOG2_WIN-1:0] out,
    output logic                       full_o
);

    localparam int WIN    = 1 << LOG2_WIN;
    localparam int SUM_W  = DATA_W + LOG2_WIN;
    localparam int FILL_W = LOG2_WIN + 1;

    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(WIN);
    localparam logic [LOG2_WIN-1:0] PTR_ONE  = LOG2_WIN'(1);
    localparam logic [FILL_W-1:0]   FILL_ONE = FILL_W'(1);

    // Converts the running sum into the value presented on out.
    function automatic logic [SUM_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
`ifdef MOVING_AVERAGE_NORM_EN
        return s >> LOG2_WIN;
`else
        return s;
`endif
    endfunction

    // Sample storage (not reset) and its write strobe.
    logic [DATA_W-1:0]   samp_q [WIN];
    logic                samp_we;

    // Window bookkeeping.
    logic [SUM_W-1:0]    sum_q,  sum_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [LOG2_WIN-1:0] wptr_q, wptr_d;

    // Output registers.
    logic [SUM_W-1:0]    out_q,   out_d;
    logic                valid_q, valid_d;
    logic                last_q,  last_d;
    logic                full_q,  full_d;

    // Intermediate values for the sample being accepted this cycle.
    logic                win_full;
    logic [DATA_W-1:0]   oldest;
    logic [SUM_W-1:0]    sum_next;
    logic [FILL_W-1:0]   fill_next;

    // Next-state computation for window bookkeeping and outputs.
    always_comb begin
        win_full  = (fill_q == FILL_MAX);
        oldest    = win_full ? samp_q[wptr_q] : '0;
        sum_next  = sum_q + SUM_W'(in) - SUM_W'(oldest);
        fill_next = win_full ? FILL_MAX : (fill_q + FILL_ONE);

        sum_d    = sum_q;
        fill_d   = fill_q;
        wptr_d   = wptr_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        full_d   = win_full;
        samp_we  = 1'b0;

        if (valid_i) begin
            samp_we = 1'b1;
            valid_d = 1'b1;
            last_d  = last_i;
            out_d   = scale_sum(sum_next);
            // full_o reports the window state that produced this result,
            // even when the sample also closes the frame.
            full_d  = (fill_next == FILL_MAX);
            if (last_i) begin
                sum_d  = '0;
                fill_d = '0;
                wptr_d = '0;
            end else begin
                sum_d  = sum_next;
                fill_d = fill_next;
                wptr_d = wptr_q + PTR_ONE;
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            fill_q  <= '0;
            wptr_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            wptr_q  <= wptr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            full_q  <= full_d;
        end
    end

    // Circular sample buffer; a sample arriving with rst is dropped.
    always_ff @(posedge clk) begin
        if (samp_we && !rst) begin
            samp_q[wptr_q] <= in;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign out     = out_q;
    assign full_o  = full_q;

endmodule
